tx_pkt_buffer: RTL

Packet buffer and egress stage on the transmit side of the dataplane. Stores every received AXI-Stream beat in a beat FIFO while the parser, flow table and action stage resolve a per-packet forward/drop decision. Pops one decision per packet, in arrival order, and either streams the packet out on the AXI-Stream TX interface or discards it. It is the consumer of the action stage's verdict and the source of the top-level TX stream.

---
 rtl/tx_pkt_buffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tx_pkt_buffer.sv
// Transmit packet buffer: beat FIFO plus per-packet forward/drop decision FIFO feeding the TX stream.
// Define TX_PKT_BUF_STATS_EN to build the forwarded/dropped packet counters; otherwise they read 0.
module tx_pkt_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512,
    parameter int DEC_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    output logic                    s_tready,
    input  logic                    dec_valid,
    input  logic                    dec_drop,
    output logic                    dec_ready,
    output logic                    m_tvalid,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [31:0]             tx_pkt_cnt,
    output logic [31:0]             drop_pkt_cnt
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int BEAT_W = DATA_WIDTH + KEEP_W + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int DAW    = $clog2(DEC_DEPTH);
    localparam logic [AW:0]  BEAT_PTR_ONE = 1;
    localparam logic [DAW:0] DEC_PTR_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DROP
    } state_t;

    state_t state_reg, state_next;

    // Beat FIFO
    logic [BEAT_W-1:0] beat_mem [DEPTH];
    logic [AW:0]       beat_wr_ptr_reg;
    logic [AW:0]       beat_rd_ptr_reg;
    logic              beat_full;
    logic              beat_empty;
    logic              beat_push;
    logic              beat_pop;
    logic [BEAT_W-1:0] beat_rd_data;
    logic              rd_last;

    // Decision FIFO
    logic              dec_mem [DEC_DEPTH];
    logic [DAW:0]      dec_wr_ptr_reg;
    logic [DAW:0]      dec_rd_ptr_reg;
    logic              dec_full;
    logic              dec_empty;
    logic              dec_push;
    logic              dec_pop;
    logic              dec_head;

    // Held low through reset so neither ingress port accepts until the first cycle after release
    logic              ready_reg;

    logic                  m_tvalid_reg;
    logic [DATA_WIDTH-1:0] m_tdata_reg;
    logic [KEEP_W-1:0]     m_tkeep_reg;
    logic                  m_tlast_reg;
    logic                  out_ready;
    logic                  send_pop;
    logic                  drop_pop;
    logic                  m_xfer_last;

    assign beat_full  = (beat_wr_ptr_reg[AW-1:0] == beat_rd_ptr_reg[AW-1:0]) &&
                        (beat_wr_ptr_reg[AW] != beat_rd_ptr_reg[AW]);
    assign beat_empty = (beat_wr_ptr_reg == beat_rd_ptr_reg);
    assign dec_full   = (dec_wr_ptr_reg[DAW-1:0] == dec_rd_ptr_reg[DAW-1:0]) &&
                        (dec_wr_ptr_reg[DAW] != dec_rd_ptr_reg[DAW]);
    assign dec_empty  = (dec_wr_ptr_reg == dec_rd_ptr_reg);

    assign s_tready  = ready_reg && !beat_full;
    assign dec_ready = ready_reg && !dec_full;
    assign beat_push = s_tvalid && s_tready;
    assign dec_push  = dec_valid && dec_ready;

    assign beat_rd_data = beat_mem[beat_rd_ptr_reg[AW-1:0]];
    assign rd_last      = beat_rd_data[0];
    assign dec_head     = dec_mem[dec_rd_ptr_reg[DAW-1:0]];

    assign out_ready   = !m_tvalid_reg || m_tready;
    assign m_xfer_last = m_tvalid_reg && m_tready && m_tlast_reg;

    always_ff @(posedge clk) begin
        if (beat_push) begin
            beat_mem[beat_wr_ptr_reg[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast};
        end
    end

    always_ff @(posedge clk) begin
        if (dec_push) begin
            dec_mem[dec_wr_ptr_reg[DAW-1:0]] <= dec_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg       <= 1'b0;
            beat_wr_ptr_reg <= '0;
            beat_rd_ptr_reg <= '0;
            dec_wr_ptr_reg  <= '0;
            dec_rd_ptr_reg  <= '0;
            state_reg       <= ST_IDLE;
        end else begin
            ready_reg <= 1'b1;
            state_reg <= state_next;
            if (beat_push) beat_wr_ptr_reg <= beat_wr_ptr_reg + BEAT_PTR_ONE;
            if (beat_pop)  beat_rd_ptr_reg <= beat_rd_ptr_reg + BEAT_PTR_ONE;
            if (dec_push)  dec_wr_ptr_reg  <= dec_wr_ptr_reg + DEC_PTR_ONE;
            if (dec_pop)   dec_rd_ptr_reg  <= dec_rd_ptr_reg + DEC_PTR_ONE;
        end
    end

    // Once the tlast beat sits in the output register, stop popping so the next packet's
    // beats wait for their own decision.
    always_comb begin
        state_next = state_reg;
        dec_pop    = 1'b0;
        send_pop   = 1'b0;
        drop_pop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!dec_empty) begin
                    dec_pop    = 1'b1;
                    state_next = dec_head ? ST_DROP : ST_SEND;
                end
            end
            ST_SEND: begin
                send_pop = !beat_empty && out_ready && !(m_tvalid_reg && m_tlast_reg);
                if (m_xfer_last) state_next = ST_IDLE;
            end
            ST_DROP: begin
                drop_pop = !beat_empty;
                if (drop_pop && rd_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign beat_pop = send_pop || drop_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
            m_tkeep_reg  <= '0;
            m_tlast_reg  <= 1'b0;
        end else if (send_pop) begin
            m_tvalid_reg <= 1'b1;
            {m_tdata_reg, m_tkeep_reg, m_tlast_reg} <= beat_rd_data;
        end else if (m_tready) begin
            m_tvalid_reg <= 1'b0;
        end
    end

    assign m_tvalid = m_tvalid_reg;
    assign m_tdata  = m_tdata_reg;
    assign m_tkeep  = m_tkeep_reg;
    assign m_tlast  = m_tlast_reg;

`ifdef TX_PKT_BUF_STATS_EN
    logic [31:0] tx_pkt_cnt_reg;
    logic [31:0] drop_pkt_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pkt_cnt_reg   <= '0;
            drop_pkt_cnt_reg <= '0;
        end else begin
            if (m_xfer_last)         tx_pkt_cnt_reg   <= tx_pkt_cnt_reg + 32'd1;
            if (drop_pop && rd_last) drop_pkt_cnt_reg <= drop_pkt_cnt_reg + 32'd1;
        end
    end

    assign tx_pkt_cnt   = tx_pkt_cnt_reg;
    assign drop_pkt_cnt = drop_pkt_cnt_reg;
`else
    assign tx_pkt_cnt   = '0;
    assign drop_pkt_cnt = '0;
`endif

endmodule
